fma_vec_checker: RTL and testbench
==================================

// Module: fma_vec_checker
// PURPOSE
//  Self-contained, synthesizable vector-driven checker for FMA units of any precision.
//  Streams packed test vectors from a sync-read vector RAM and drives the FMA DUT one vector per cycle.
//  Compares result/flags after a parametrised pipeline latency; reports error count, first failure and done.
//  Replaces the free-running $readmemh bench loop for pipelined fma16/fma32/fma64 and FPGA bring-up.
// PARAMETERS
//  FLEN     16     operand/result width (16, 32, 64)
//  NF       4      flag width {invalid, overflow, underflow, inexact}
//  LATENCY  0      DUT register stages, input to result (0 = combinational)
//  AW       14     vector RAM address width (max 2^AW vectors)
//  VW       4*FLEN+8+NF  packed vector width {x,y,z,ctrl[7:0],rexp,flagsexp} (76 at FLEN=16)
// PORTS
//  clk          in   1     clock
//  reset        in   1     synchronous, active-high
//  start        in   1     begin run (sampled in IDLE/DONE only)
//  num_vectors  in   AW+1  vectors to run, sampled with start
//  nan_equiv    in   1     1: any NaN result matches any expected NaN
//  mem_addr     out  AW    vector RAM read address
//  mem_rdata    in   VW    vector RAM data, valid 1 cycle after mem_addr
//  x, y, z      out  FLEN  DUT operands (registered)
//  ctrl         out  8     {2'b0, roundmode[1:0], mul, add, negp, negz} to DUT (registered)
//  result       in   FLEN  DUT result
//  flags        in   NF    DUT flags
//  busy         out  1     run in progress
//  done         out  1     run complete; held until next start or reset
//  err_pulse    out  1     1-cycle pulse on each mismatching compare
//  err_index    out  AW    index of vector compared when err_pulse high
//  errors       out  32    mismatch count, saturates at 32'hFFFF_FFFF
//  first_fail   out  AW    index of first mismatch (valid when errors != 0)
//  vec_count    out  AW+1  vectors compared this run
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 incl. x/y/z/ctrl; pipeline valid bits cleared. Reset mid-run aborts immediately.
//  FSM: IDLE -start-> RUN; RUN -last addr issued-> DRAIN; DRAIN -last compare-> DONE; DONE -start-> RUN.
//   start clears errors/first_fail/vec_count/done. start while busy is ignored.
//  Timing (start high in cycle 0): mem_addr=k in cycle k+1 (k=0..N-1); rdata captured end of cycle k+2.
//   DUT inputs hold vector k during cycle k+3. Compare for k at end of cycle k+3+LATENCY.
//   Throughput: 1 vector/cycle, no bubbles. done rises in cycle N+4+LATENCY.
//   N=0: no reads, no DUT activity; done rises in cycle 2.
//  Expected {rexp, flagsexp, index, valid} travel in a LATENCY+1-deep shift register aligned with DUT.
//  Match: (result == rexp, or nan_equiv and both are NaN: exp all ones, frac != 0) and flags == flagsexp.
//  Mismatch: err_pulse=1, err_index=k, errors++ (saturating); first_fail latched on the first mismatch only.
//  vec_count increments on every compare (match or not); equals N at done.
//  busy=1 in RUN and DRAIN. x/y/z/ctrl hold the last vector after the run; no re-drive until next start.
//  mem_addr holds last issued value outside RUN.
// TESTING
//  1. LATENCY=0, N=3 matching vectors (fma16 3C00*4000+0000=4000, flags 0) -> done cycle 7, errors=0, vec_count=3.
//  2. Vector 1 rexp=3C01, DUT gives 3C00 -> err_pulse once, err_index=1, errors=1, first_fail=1.
//  3. Result match, flagsexp=0001, DUT flags=0000 -> errors=1; vectors 0,2 clean.
//  4. LATENCY=3, N=100 back-to-back -> new x each cycle 3..102, done cycle 107, vec_count=100.
//  5. nan_equiv=1, rexp=7E00, result=7C01 -> match; nan_equiv=0 same -> errors=1.
//  6. N=0 -> done cycle 2, errors=0. Reset in cycle 5 of a run -> all outputs 0 next cycle.
//     Then start -> clean re-run.

Source files
------------

// File: rtl/fma_vec_checker.sv
// Vector-driven checker for pipelined FMA units.
// Streams packed vectors from a sync-read RAM, drives the FMA operands once per
// cycle and compares result/flags after LATENCY cycles. It counts mismatches,
// latches the first failing index and raises done once every compare is finished.
module fma_vec_checker #(
    parameter int FLEN    = 16,
    parameter int NF      = 4,
    parameter int LATENCY = 0,
    parameter int AW      = 14,
    parameter int VW      = 4*FLEN+8+NF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [AW:0]     num_vectors,
    input  logic            nan_equiv,
    output logic [AW-1:0]   mem_addr,
    input  logic [VW-1:0]   mem_rdata,
    output logic [FLEN-1:0] x,
    output logic [FLEN-1:0] y,
    output logic [FLEN-1:0] z,
    output logic [7:0]      ctrl,
    input  logic [FLEN-1:0] result,
    input  logic [NF-1:0]   flags,
    output logic            busy,
    output logic            done,
    output logic            err_pulse,
    output logic [AW-1:0]   err_index,
    output logic [31:0]     errors,
    output logic [AW-1:0]   first_fail,
    output logic [AW:0]     vec_count
);
    localparam int EW = (FLEN == 16) ? 5 : ((FLEN == 32) ? 8 : 11);
    localparam int MW = FLEN - 1 - EW;
    localparam int PD = LATENCY + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // NaN: exponent all ones with a non-zero fraction.
    function automatic logic is_nan(input logic [FLEN-1:0] v);
        return (&v[FLEN-2:MW]) && (|v[MW-1:0]);
    endfunction

    state_t                   state_q, state_d;
    logic [AW-1:0]            mem_addr_q, mem_addr_d;
    logic [AW:0]              nvec_q, nvec_d;
    logic [AW:0]              issue_cnt_q, issue_cnt_d;
    logic                     rd_v_q, rd_v_d;
    logic                     rd2_v_q, rd2_v_d;
    logic [AW-1:0]            rd2_idx_q, rd2_idx_d;
    logic [FLEN-1:0]          x_q, x_d, y_q, y_d, z_q, z_d;
    logic [7:0]               ctrl_q, ctrl_d;
    logic [PD-1:0]            pv_q, pv_d;
    logic [PD-1:0][FLEN-1:0]  pres_q, pres_d;
    logic [PD-1:0][NF-1:0]    pflg_q, pflg_d;
    logic [PD-1:0][AW-1:0]    pidx_q, pidx_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     err_pulse_q, err_pulse_d;
    logic [AW-1:0]            err_index_q, err_index_d;
    logic [31:0]              errors_q, errors_d;
    logic [AW-1:0]            first_fail_q, first_fail_d;
    logic [AW:0]              vec_count_q, vec_count_d;

    logic                     cmp_valid_s;
    logic                     match_s;
    logic                     empty_s;

    assign cmp_valid_s = pv_q[LATENCY];
    assign match_s     = ((result == pres_q[LATENCY]) ||
                          (nan_equiv && is_nan(result) && is_nan(pres_q[LATENCY]))) &&
                         (flags == pflg_q[LATENCY]);
    // Nothing left in flight: no read pending, no captured vector, no expected entry.
    assign empty_s     = !rd_v_q && !rd2_v_q && !(|pv_q);

    // Next-state, read issue, operand capture, expected-value pipeline and scoring.
    always_comb begin
        state_d      = state_q;
        mem_addr_d   = mem_addr_q;
        nvec_d       = nvec_q;
        issue_cnt_d  = issue_cnt_q;
        rd_v_d       = 1'b0;
        rd2_v_d      = rd_v_q;
        rd2_idx_d    = mem_addr_q;
        x_d          = x_q;
        y_d          = y_q;
        z_d          = z_q;
        ctrl_d       = ctrl_q;
        busy_d       = busy_q;
        done_d       = done_q;
        err_pulse_d  = 1'b0;
        err_index_d  = err_index_q;
        errors_d     = errors_q;
        first_fail_d = first_fail_q;
        vec_count_d  = vec_count_q;

        // Expected values enter alongside the operands and age with the FMA pipeline.
        pv_d      = pv_q;
        pres_d    = pres_q;
        pflg_d    = pflg_q;
        pidx_d    = pidx_q;
        pv_d[0]   = rd2_v_q;
        pres_d[0] = mem_rdata[NF +: FLEN];
        pflg_d[0] = mem_rdata[NF-1:0];
        pidx_d[0] = rd2_idx_q;
        for (int i = 1; i < PD; i++) begin
            pv_d[i]   = pv_q[i-1];
            pres_d[i] = pres_q[i-1];
            pflg_d[i] = pflg_q[i-1];
            pidx_d[i] = pidx_q[i-1];
        end

        // Operands change only when a fresh vector arrives, so they hold after a run.
        if (rd2_v_q) begin
            x_d    = mem_rdata[VW-1 -: FLEN];
            y_d    = mem_rdata[VW-1-FLEN -: FLEN];
            z_d    = mem_rdata[VW-1-2*FLEN -: FLEN];
            ctrl_d = mem_rdata[NF+FLEN +: 8];
        end else begin
            x_d    = x_q;
            y_d    = y_q;
            z_d    = z_q;
            ctrl_d = ctrl_q;
        end

        if (cmp_valid_s) begin
            vec_count_d = vec_count_q + {{AW{1'b0}}, 1'b1};
            if (!match_s) begin
                err_pulse_d = 1'b1;
                err_index_d = pidx_q[LATENCY];
                if (errors_q != 32'hFFFF_FFFF) begin
                    errors_d = errors_q + 32'd1;
                end else begin
                    errors_d = errors_q;
                end
                if (errors_q == 32'd0) begin
                    first_fail_d = pidx_q[LATENCY];
                end else begin
                    first_fail_d = first_fail_q;
                end
            end else begin
                err_pulse_d = 1'b0;
            end
        end else begin
            vec_count_d = vec_count_q;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d      = S_RUN;
                    nvec_d       = num_vectors;
                    errors_d     = 32'd0;
                    first_fail_d = {AW{1'b0}};
                    vec_count_d  = {(AW+1){1'b0}};
                    done_d       = 1'b0;
                    busy_d       = 1'b1;
                    if (num_vectors != {(AW+1){1'b0}}) begin
                        mem_addr_d  = {AW{1'b0}};
                        rd_v_d      = 1'b1;
                        issue_cnt_d = {{AW{1'b0}}, 1'b1};
                    end else begin
                        rd_v_d      = 1'b0;
                        issue_cnt_d = {(AW+1){1'b0}};
                    end
                end else begin
                    state_d = state_q;
                end
            end
            S_RUN: begin
                if (issue_cnt_q < nvec_q) begin
                    mem_addr_d  = issue_cnt_q[AW-1:0];
                    rd_v_d      = 1'b1;
                    issue_cnt_d = issue_cnt_q + {{AW{1'b0}}, 1'b1};
                end else if (nvec_q == {(AW+1){1'b0}}) begin
                    // Empty run: nothing was read, finish straight away.
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (empty_s) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any run and clears everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            mem_addr_q   <= {AW{1'b0}};
            nvec_q       <= {(AW+1){1'b0}};
            issue_cnt_q  <= {(AW+1){1'b0}};
            rd_v_q       <= 1'b0;
            rd2_v_q      <= 1'b0;
            rd2_idx_q    <= {AW{1'b0}};
            x_q          <= {FLEN{1'b0}};
            y_q          <= {FLEN{1'b0}};
            z_q          <= {FLEN{1'b0}};
            ctrl_q       <= 8'h00;
            pv_q         <= {PD{1'b0}};
            pres_q       <= {(PD*FLEN){1'b0}};
            pflg_q       <= {(PD*NF){1'b0}};
            pidx_q       <= {(PD*AW){1'b0}};
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_pulse_q  <= 1'b0;
            err_index_q  <= {AW{1'b0}};
            errors_q     <= 32'd0;
            first_fail_q <= {AW{1'b0}};
            vec_count_q  <= {(AW+1){1'b0}};
        end else begin
            state_q      <= state_d;
            mem_addr_q   <= mem_addr_d;
            nvec_q       <= nvec_d;
            issue_cnt_q  <= issue_cnt_d;
            rd_v_q       <= rd_v_d;
            rd2_v_q      <= rd2_v_d;
            rd2_idx_q    <= rd2_idx_d;
            x_q          <= x_d;
            y_q          <= y_d;
            z_q          <= z_d;
            ctrl_q       <= ctrl_d;
            pv_q         <= pv_d;
            pres_q       <= pres_d;
            pflg_q       <= pflg_d;
            pidx_q       <= pidx_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_pulse_q  <= err_pulse_d;
            err_index_q  <= err_index_d;
            errors_q     <= errors_d;
            first_fail_q <= first_fail_d;
            vec_count_q  <= vec_count_d;
        end
    end

    assign mem_addr   = mem_addr_q;
    assign x          = x_q;
    assign y          = y_q;
    assign z          = z_q;
    assign ctrl       = ctrl_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err_pulse  = err_pulse_q;
    assign err_index  = err_index_q;
    assign errors     = errors_q;
    assign first_fail = first_fail_q;
    assign vec_count  = vec_count_q;
endmodule

// File: tb/tb_fma_vec_checker.sv
// Bench for fma_vec_checker: two checkers (LATENCY 0 and 3) share one vector
// RAM and each drives a stand-in FMA. Expected outcomes come from a vector-level
// model of the match rule plus the documented cycle timing.
module tb_fma_vec_checker;
    localparam int FLEN = 16;
    localparam int NF   = 4;
    localparam int AW   = 14;
    localparam int VW   = 4*FLEN+8+NF;
    localparam int LAT [2] = '{0, 3};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset, start, nan_equiv;
    logic [AW:0]     num_vectors;
    logic [AW-1:0]   mem_addr [2];
    logic [VW-1:0]   rdata [2];
    logic [FLEN-1:0] x [2], y [2], z [2];
    logic [7:0]      ctrl [2];
    logic [FLEN-1:0] result0, result3;
    logic [NF-1:0]   flags0, flags3;
    logic            busy [2], done [2], err_pulse [2];
    logic [AW-1:0]   err_index [2], first_fail [2];
    logic [31:0]     errors [2];
    logic [AW:0]     vec_count [2];

    logic [VW-1:0]   vmem [0:255];
    int checks = 0;
    int failures = 0;

    // Stand-in FMA: exact for 1.0*y+0, an arbitrary bit mix otherwise.
    function automatic logic [FLEN-1:0] fake_res(input logic [FLEN-1:0] a, b, c);
        if (a == 16'h3C00 && c == 16'h0000) return b;
        else return a ^ b ^ c ^ 16'h5A5A;
    endfunction
    function automatic logic [NF-1:0] fake_flg(input logic [FLEN-1:0] a, b, c);
        if (a == 16'h3C00 && c == 16'h0000) return 4'h0;
        else return a[3:0] ^ b[3:0];
    endfunction

    fma_vec_checker #(.FLEN(FLEN), .NF(NF), .LATENCY(0), .AW(AW)) u_l0 (
        .clk(clk), .reset(reset), .start(start), .num_vectors(num_vectors),
        .nan_equiv(nan_equiv), .mem_addr(mem_addr[0]), .mem_rdata(rdata[0]),
        .x(x[0]), .y(y[0]), .z(z[0]), .ctrl(ctrl[0]), .result(result0), .flags(flags0),
        .busy(busy[0]), .done(done[0]), .err_pulse(err_pulse[0]), .err_index(err_index[0]),
        .errors(errors[0]), .first_fail(first_fail[0]), .vec_count(vec_count[0]));

    fma_vec_checker #(.FLEN(FLEN), .NF(NF), .LATENCY(3), .AW(AW)) u_l3 (
        .clk(clk), .reset(reset), .start(start), .num_vectors(num_vectors),
        .nan_equiv(nan_equiv), .mem_addr(mem_addr[1]), .mem_rdata(rdata[1]),
        .x(x[1]), .y(y[1]), .z(z[1]), .ctrl(ctrl[1]), .result(result3), .flags(flags3),
        .busy(busy[1]), .done(done[1]), .err_pulse(err_pulse[1]), .err_index(err_index[1]),
        .errors(errors[1]), .first_fail(first_fail[1]), .vec_count(vec_count[1]));

    // Synchronous-read vector RAM, one port per checker.
    always @(posedge clk) begin
        rdata[0] <= vmem[mem_addr[0][7:0]];
        rdata[1] <= vmem[mem_addr[1][7:0]];
    end

    assign result0 = fake_res(x[0], y[0], z[0]);
    assign flags0  = fake_flg(x[0], y[0], z[0]);

    logic [FLEN-1:0] p1r, p2r, p3r;
    logic [NF-1:0]   p1f, p2f, p3f;
    // Three-stage stand-in FMA for the LATENCY=3 checker.
    always @(posedge clk) begin
        p1r <= fake_res(x[1], y[1], z[1]);
        p1f <= fake_flg(x[1], y[1], z[1]);
        p2r <= p1r; p2f <= p1f;
        p3r <= p2r; p3f <= p2f;
    end
    assign result3 = p3r;
    assign flags3  = p3f;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [VW-1:0] mkvec(input logic [15:0] a, b, c, input logic [7:0] ct,
                                            input logic [15:0] re, input logic [3:0] fe);
        return {a, b, c, ct, re, fe};
    endfunction

    function automatic bit nan16(input logic [15:0] v);
        return (((v >> 10) & 16'h001F) == 16'h001F) && ((v & 16'h03FF) != 16'h0000);
    endfunction

    // Vector-level rule: does the stand-in FMA's answer satisfy this vector?
    function automatic bit vec_ok(input logic [VW-1:0] v, input bit ne);
        logic [15:0] res;
        logic [3:0]  flg;
        bit          rok;
        res = fake_res(v[75:60], v[59:44], v[43:28]);
        flg = fake_flg(v[75:60], v[59:44], v[43:28]);
        rok = (res == v[19:4]) || (ne && nan16(res) && nan16(v[19:4]));
        return rok && (flg == v[3:0]);
    endfunction

    task automatic chk_zero(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s/i%0d/busy", tag, i), busy[i], 0);
            chk($sformatf("%s/i%0d/done", tag, i), done[i], 0);
            chk($sformatf("%s/i%0d/err_pulse", tag, i), err_pulse[i], 0);
            chk($sformatf("%s/i%0d/err_index", tag, i), err_index[i], 0);
            chk($sformatf("%s/i%0d/errors", tag, i), errors[i], 0);
            chk($sformatf("%s/i%0d/first_fail", tag, i), first_fail[i], 0);
            chk($sformatf("%s/i%0d/vec_count", tag, i), vec_count[i], 0);
            chk($sformatf("%s/i%0d/mem_addr", tag, i), mem_addr[i], 0);
            chk($sformatf("%s/i%0d/xyzc", tag, i), {x[i], y[i], z[i], ctrl[i]}, 0);
        end
    endtask

    // Start a run of n vectors and check timing, operands, pulses and final counters.
    task automatic run_check(input int n, input bit ne, input string tag);
        int expq[$];
        int done_cyc [2];
        int pn [2];
        int want_done;
        for (int k = 0; k < n; k++) if (!vec_ok(vmem[k], ne)) expq.push_back(k);
        done_cyc = '{-1, -1};
        pn = '{0, 0};
        @(negedge clk);
        start = 1'b1; num_vectors = n[AW:0]; nan_equiv = ne;
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            start = 1'b0;
            for (int i = 0; i < 2; i++) begin
                if (c <= n) chk($sformatf("%s/i%0d/mem_addr@%0d", tag, i, c), mem_addr[i], c - 1);
                if (c >= 3 && c <= n + 2)
                    chk($sformatf("%s/i%0d/operands@%0d", tag, i, c),
                        {x[i], y[i], z[i], ctrl[i]}, vmem[c-3][VW-1:NF+FLEN]);
                if (err_pulse[i]) begin
                    if (pn[i] < expq.size()) begin
                        chk($sformatf("%s/i%0d/err_index", tag, i), err_index[i], expq[pn[i]]);
                        chk($sformatf("%s/i%0d/err_cycle", tag, i), c, expq[pn[i]] + 4 + LAT[i]);
                    end else begin
                        chk($sformatf("%s/i%0d/extra_err_pulse@%0d", tag, i, c), 1, 0);
                    end
                    pn[i]++;
                end
                if (done[i] && done_cyc[i] < 0) done_cyc[i] = c;
            end
            if (done_cyc[0] >= 0 && done_cyc[1] >= 0) break;
        end
        for (int i = 0; i < 2; i++) begin
            want_done = (n == 0) ? 2 : n + 4 + LAT[i];
            chk($sformatf("%s/i%0d/done_cycle", tag, i), done_cyc[i], want_done);
            chk($sformatf("%s/i%0d/busy_end", tag, i), busy[i], 0);
            chk($sformatf("%s/i%0d/errors", tag, i), errors[i], expq.size());
            chk($sformatf("%s/i%0d/pulses", tag, i), pn[i], expq.size());
            chk($sformatf("%s/i%0d/vec_count", tag, i), vec_count[i], n);
            if (expq.size() > 0)
                chk($sformatf("%s/i%0d/first_fail", tag, i), first_fail[i], expq[0]);
        end
    endtask

    task automatic gen_rand(input int n);
        logic [31:0] r;
        logic [15:0] a, b, c, re;
        logic [3:0]  fe;
        int kind;
        for (int k = 0; k < n; k++) begin
            r = $urandom; a = r[15:0]; b = r[31:16];
            r = $urandom; c = r[15:0];
            kind = $urandom_range(0, 9);
            if (kind >= 8) begin
                a = 16'h3C00; c = 16'h0000;
                b = {r[16], 5'h1F, 10'h001 | r[27:18]};
            end
            re = fake_res(a, b, c);
            fe = fake_flg(a, b, c);
            if (kind == 6) re = re ^ (16'h0001 << r[19:16]);
            if (kind == 7) fe = fe ^ (4'h1 << r[21:20]);
            if (kind == 8) re = 16'h7E00;
            if (kind == 9) re = 16'h7C00;
            vmem[k] = mkvec(a, b, c, {2'b00, r[29:24]}, re, fe);
        end
    endtask

    typedef struct {
        int          n;
        bit          ne;
        logic [15:0] y1;
        logic [15:0] rexp1;
        logic [3:0]  fexp1;
        int          exp_err;
        int          exp_first;
    } dcase_t;

    initial begin
        dcase_t tbl [5];
        tbl[0] = '{3, 1'b0, 16'h4000, 16'h4000, 4'h0, 0, 0};
        tbl[1] = '{3, 1'b0, 16'h4000, 16'h3C01, 4'h0, 1, 1};
        tbl[2] = '{3, 1'b0, 16'h4000, 16'h4000, 4'h1, 1, 1};
        tbl[3] = '{3, 1'b1, 16'h7C01, 16'h7E00, 4'h0, 0, 0};
        tbl[4] = '{3, 1'b0, 16'h7C01, 16'h7E00, 4'h0, 1, 1};

        reset = 1'b1; start = 1'b0; num_vectors = '0; nan_equiv = 1'b0;
        for (int k = 0; k < 256; k++) vmem[k] = '0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        reset = 1'b0;

        // Directed cases: 1.0*2.0+0 = 2.0 with vector 1 varied.
        for (int t = 0; t < 5; t++) begin
            for (int k = 0; k < 3; k++)
                vmem[k] = mkvec(16'h3C00, 16'h4000, 16'h0000, 8'h0C, 16'h4000, 4'h0);
            vmem[1] = mkvec(16'h3C00, tbl[t].y1, 16'h0000, 8'h0C, tbl[t].rexp1, tbl[t].fexp1);
            run_check(tbl[t].n, tbl[t].ne, $sformatf("dir%0d", t));
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("dir%0d/i%0d/tbl_errors", t, i), errors[i], tbl[t].exp_err);
                if (tbl[t].exp_err > 0)
                    chk($sformatf("dir%0d/i%0d/tbl_first", t, i), first_fail[i], tbl[t].exp_first);
            end
        end

        run_check(0, 1'b0, "empty");

        gen_rand(100);
        run_check(100, 1'b0, "long100");

        for (int r = 0; r < 5; r++) begin
            int n;
            n = $urandom_range(1, 64);
            gen_rand(n);
            run_check(n, $urandom_range(0, 1) == 1, $sformatf("rand%0d", r));
        end

        // Reset in cycle 5 of a run, then a clean re-run.
        gen_rand(20);
        @(negedge clk);
        start = 1'b1; num_vectors = 15'd20; nan_equiv = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        chk_zero("midrun_reset");
        reset = 1'b0;
        run_check(20, 1'b0, "rerun");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
